multi_cycle_sequencer: RTL and testbench
========================================

Name: multi_cycle_sequencer

Overview:
- Consumes the level-type control word from the opcode decoder, together with op/func from the instruction register and the ALU flags.
- Sequences each instruction through the IF/ID/EXE/MEM/WB cycles.
- Emits cycle-qualified write/read strobes to the PC, IR, register file and data memory.
- Receiving end of the decoder's control-word interface; sits between the decoder and the datapath of the multi-cycle CPU.

Parameters:
- CNT_W, 32, width of the performance counters (used only with SEQ_PERF_CNT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  6  IR opcode field; valid from ID onward.
- func  in  6  IR function field; valid from ID onward.
- reg_write_d  in  1  decoder RegWrite level.
- mem_write_d  in  1  decoder MemWrite level.
- mem_read_d  in  1  decoder MemRead level.
- pc_write_d  in  1  decoder PCWrite_C level (0 only for halt).
- pc_src_d  in  2  decoder PCSrc.
- zero_op_d  in  2  decoder branch-condition select.
- zero  in  1  ALU result == 0.
- sign  in  1  ALU result sign bit.
- mem_ready  in  1  data memory access complete.
- state  out  3  current state code.
- ir_we  out  1  IR load strobe.
- pc_we  out  1  PC write strobe.
- pc_src  out  2  PC mux select qualified by branch outcome.
- reg_we  out  1  register-file write strobe.
- mem_we  out  1  data memory write strobe.
- mem_re  out  1  data memory read strobe.
- halted  out  1  high while in HALT.
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction.
- cycle_cnt  out  CNT_W  cycles since reset (feature only).
- instr_cnt  out  CNT_W  retired instructions (feature only).

Behaviour:

Reset and timing:
- Reset is asynchronous and active-low: clk is the only clock; rst_n low clears all state immediately.
- Reset values: state=IF, counters=0.
- All strobes, halted and instr_done are forced 0 while rst_n is low.
- Outputs are combinational from state, decoded inputs and flags. The state register is the only sequential element apart from the counters.

State encoding:
- IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=101.
- Codes 110 and 111 are illegal and go to IF on the next clock.

Instruction classes (decoded from op/func):
- JMP: op 000010, op 000011, or op 000000 with func 001000.
- BR: op 000100, 000101, 000110.
- LW: op 100011.
- SW: op 101011.
- HLT: op 111111.
- ALU: everything else.

State sequencing:
- IF: ir_we=1 -> ID.
- ID:
  - JMP: pc_we=1, pc_src=pc_src_d, reg_we=reg_write_d (jal link write), instr_done=1 -> IF.
  - HLT: pc_we=0, instr_done=1 -> HALT.
  - All other classes -> EXE.
- EXE:
  - BR: pc_we=1, instr_done=1 -> IF.
    - pc_src = taken ? pc_src_d : 00.
    - taken: zero_op_d=00 -> zero; 01 -> !zero; 10 -> sign; 11 -> not taken.
  - LW and SW -> MEM.
  - ALU -> WB.
- MEM:
  - mem_re=mem_read_d and mem_we=mem_write_d, held every cycle until mem_ready=1.
  - mem_ready=0: stay in MEM.
  - mem_ready=1 with SW: pc_we=1, pc_src=00, instr_done=1 -> IF.
  - mem_ready=1 with LW -> WB.
- WB: reg_we=reg_write_d, pc_we=1, pc_src=00, instr_done=1 -> IF.
- HALT: all strobes 0, halted=1; leaves only on reset.

Strobe rules:
- pc_we is always ANDed with pc_write_d.
- pc_src=00 in every state where pc_we=0.
- Exactly one pc_we pulse per retired instruction; none for halt.

Latencies:
- JMP 2 cycles; BR 3; ALU 4; SW 4+waits; LW 5+waits.
- One wait cycle is added per MEM cycle with mem_ready=0.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- Defined:
  - cycle_cnt increments every clock outside reset, including in HALT.
  - instr_cnt increments on each instr_done, including halt's.
  - Both wrap modulo 2^CNT_W.
- Undefined:
  - Counters are not instantiated; cycle_cnt and instr_cnt are tied to 0.

Test Plan:
- ALU add (op 000000 func 100000, reg_write_d=1) from reset -> states 000,001,010,100; reg_we=1 and pc_we=1 only in WB; instr_done at cycle 4.
- beq (op 000100, zero_op_d=00, pc_src_d=01): zero=1 -> EXE shows pc_we=1, pc_src=01; repeat with zero=0 -> pc_src=00; 3 cycles each.
- lw with mem_ready held low 2 cycles -> MEM lasts 3 cycles with mem_re=1 throughout; WB reg_we=1; total 7 cycles.
- jal (op 000011, pc_src_d=10, reg_write_d=1) -> ID asserts pc_we=1, pc_src=10, reg_we=1; back to IF after 2 cycles.
- halt (op 111111, pc_write_d=0) -> HALT after ID; pc_we never 1; halted=1 for 10 idle cycles; rst_n pulse low -> state=000 immediately.
- rst_n asserted in MEM mid-lw -> mem_re drops to 0 asynchronously, state=IF; with SEQ_PERF_CNT_EN both counters read 0.

Source files
------------

// File: rtl/multi_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_sequencer
// Purpose  : Multi-cycle CPU control sequencer. It takes the decoder's
//            level-type control word, op/func and the ALU flags, walks each
//            instruction through IF/ID/EXE/MEM/WB, and issues cycle-qualified
//            strobes to the PC, IR, register file and data memory.
// Options  : SEQ_PERF_CNT_EN adds cycle and retired-instruction counters.
// Revision : 1.0 - initial release
// ============================================================================
module multi_cycle_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             reg_write_d,
    input  logic             mem_write_d,
    input  logic             mem_read_d,
    input  logic             pc_write_d,
    input  logic [1:0]       pc_src_d,
    input  logic [1:0]       zero_op_d,
    input  logic             zero,
    input  logic             sign,
    input  logic             mem_ready,
    output logic [2:0]       state,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             reg_we,
    output logic             mem_we,
    output logic             mem_re,
    output logic             halted,
    output logic             instr_done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b101
    } state_t;

    state_t     cur_state;
    state_t     nxt_state;

    logic       is_jmp;
    logic       is_br;
    logic       is_lw;
    logic       is_sw;
    logic       is_hlt;
    logic       br_taken;

    logic       ir_we_raw;
    logic       pc_we_raw;
    logic [1:0] pc_src_raw;
    logic       reg_we_raw;
    logic       mem_we_raw;
    logic       mem_re_raw;
    logic       halted_raw;
    logic       done_raw;

    // Instruction class decode; anything not listed is treated as ALU.
    assign is_jmp = (op == 6'b000010) || (op == 6'b000011) ||
                    ((op == 6'b000000) && (func == 6'b001000));
    assign is_br  = (op == 6'b000100) || (op == 6'b000101) || (op == 6'b000110);
    assign is_lw  = (op == 6'b100011);
    assign is_sw  = (op == 6'b101011);
    assign is_hlt = (op == 6'b111111);

    // Branch condition select: zero, not-zero, sign, never.
    always_comb begin
        br_taken = 1'b0;
        case (zero_op_d)
            2'b00:   br_taken = zero;
            2'b01:   br_taken = ~zero;
            2'b10:   br_taken = sign;
            default: br_taken = 1'b0;
        endcase
    end

    // State register; reset returns to instruction fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_IF;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state and raw strobe generation.
    always_comb begin
        nxt_state  = cur_state;
        ir_we_raw  = 1'b0;
        pc_we_raw  = 1'b0;
        pc_src_raw = 2'b00;
        reg_we_raw = 1'b0;
        mem_we_raw = 1'b0;
        mem_re_raw = 1'b0;
        halted_raw = 1'b0;
        done_raw   = 1'b0;
        case (cur_state)
            S_IF: begin
                ir_we_raw = 1'b1;
                nxt_state = S_ID;
            end
            S_ID: begin
                if (is_jmp) begin
                    pc_we_raw  = 1'b1;
                    pc_src_raw = pc_src_d;
                    reg_we_raw = reg_write_d;   // jal link write
                    done_raw   = 1'b1;
                    nxt_state  = S_IF;
                end else if (is_hlt) begin
                    done_raw   = 1'b1;
                    nxt_state  = S_HALT;
                end else begin
                    nxt_state  = S_EXE;
                end
            end
            S_EXE: begin
                if (is_br) begin
                    pc_we_raw  = 1'b1;
                    pc_src_raw = br_taken ? pc_src_d : 2'b00;
                    done_raw   = 1'b1;
                    nxt_state  = S_IF;
                end else if (is_lw || is_sw) begin
                    nxt_state  = S_MEM;
                end else begin
                    nxt_state  = S_WB;
                end
            end
            S_MEM: begin
                // Request is held until the memory acknowledges.
                mem_re_raw = mem_read_d;
                mem_we_raw = mem_write_d;
                if (mem_ready) begin
                    if (is_sw) begin
                        pc_we_raw = 1'b1;
                        done_raw  = 1'b1;
                        nxt_state = S_IF;
                    end else begin
                        nxt_state = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we_raw = reg_write_d;
                pc_we_raw  = 1'b1;
                done_raw   = 1'b1;
                nxt_state  = S_IF;
            end
            S_HALT: begin
                halted_raw = 1'b1;
                nxt_state  = S_HALT;
            end
            default: begin
                nxt_state  = S_IF;          // recover from illegal codes
            end
        endcase
    end

    // Final qualification: gate by reset and PCWrite, keep pc_src quiet when idle.
    always_comb begin
        pc_we      = rst_n & pc_we_raw & pc_write_d;
        pc_src     = pc_we ? pc_src_raw : 2'b00;
        ir_we      = rst_n & ir_we_raw;
        reg_we     = rst_n & reg_we_raw;
        mem_we     = rst_n & mem_we_raw;
        mem_re     = rst_n & mem_re_raw;
        halted     = rst_n & halted_raw;
        instr_done = rst_n & done_raw;
    end

    assign state = cur_state;

`ifdef SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] instr_q;

    // Free-running cycle counter and retired-instruction counter, both wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            cycle_q <= cycle_q + 1'b1;
            if (done_raw) begin
                instr_q <= instr_q + 1'b1;
            end
        end
    end

    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_cycle_sequencer
// Purpose  : Directed self-checking bench for multi_cycle_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_cycle_sequencer;

    localparam int CNT_W = 32;

    logic             clk;
    logic             rst_n;
    logic [5:0]       op;
    logic [5:0]       func;
    logic             reg_write_d;
    logic             mem_write_d;
    logic             mem_read_d;
    logic             pc_write_d;
    logic [1:0]       pc_src_d;
    logic [1:0]       zero_op_d;
    logic             zero;
    logic             sign;
    logic             mem_ready;
    logic [2:0]       state;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       pc_src;
    logic             reg_we;
    logic             mem_we;
    logic             mem_re;
    logic             halted;
    logic             instr_done;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instr_cnt;

    int n_assert;
    int n_fail;

    multi_cycle_sequencer #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op          (op),
        .func        (func),
        .reg_write_d (reg_write_d),
        .mem_write_d (mem_write_d),
        .mem_read_d  (mem_read_d),
        .pc_write_d  (pc_write_d),
        .pc_src_d    (pc_src_d),
        .zero_op_d   (zero_op_d),
        .zero        (zero),
        .sign        (sign),
        .mem_ready   (mem_ready),
        .state       (state),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .pc_src      (pc_src),
        .reg_we      (reg_we),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .halted      (halted),
        .instr_done  (instr_done),
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed output word: state, ir_we, pc_we, pc_src, reg_we, mem_we, mem_re, halted, instr_done
    logic [11:0] obs;
    assign obs = {state, ir_we, pc_we, pc_src, reg_we, mem_we, mem_re, halted, instr_done};

    function automatic logic [11:0] ex(input logic [2:0] st, input logic ir, input logic pw,
                                       input logic [1:0] ps, input logic rw, input logic mw,
                                       input logic mr, input logic hl, input logic dn);
        return {st, ir, pw, ps, rw, mw, mr, hl, dn};
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // Check outputs of the current cycle, then advance to the next one.
    task automatic cyc(input string tag, input logic [11:0] e);
        #1;
        check(tag, {20'd0, obs}, {20'd0, e});
        @(negedge clk);
    endtask

    task automatic set_in(input logic [5:0] o, input logic [5:0] f, input logic rw,
                          input logic mw, input logic mr, input logic pw,
                          input logic [1:0] ps, input logic [1:0] zo);
        op = o; func = f; reg_write_d = rw; mem_write_d = mw; mem_read_d = mr;
        pc_write_d = pw; pc_src_d = ps; zero_op_d = zo;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n = 1'b0; zero = 1'b0; sign = 1'b0; mem_ready = 1'b0;
        set_in(6'b000000, 6'b100000, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00);

        // Reset: IF state, all strobes forced low.
        #1;
        check("reset_outs", {20'd0, obs}, {20'd0, ex(3'b000,0,0,2'b00,0,0,0,0,0)});
        check("reset_cyc", cycle_cnt, 32'd0);
        check("reset_ins", instr_cnt, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU add, pc_src_d deliberately non-zero: WB must still drive 00.
        cyc("alu_if",  ex(3'b000,1,0,2'b00,0,0,0,0,0));
        cyc("alu_id",  ex(3'b001,0,0,2'b00,0,0,0,0,0));
        cyc("alu_exe", ex(3'b010,0,0,2'b00,0,0,0,0,0));
        cyc("alu_wb",  ex(3'b100,0,1,2'b00,1,0,0,0,1));

        // beq taken
        set_in(6'b000100, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00);
        zero = 1'b1;
        cyc("beqt_if",  ex(3'b000,1,0,2'b00,0,0,0,0,0));
        cyc("beqt_id",  ex(3'b001,0,0,2'b00,0,0,0,0,0));
        cyc("beqt_exe", ex(3'b010,0,1,2'b01,0,0,0,0,1));
        // beq not taken
        zero = 1'b0;
        cyc("beqn_if",  ex(3'b000,1,0,2'b00,0,0,0,0,0));
        cyc("beqn_id",  ex(3'b001,0,0,2'b00,0,0,0,0,0));
        cyc("beqn_exe", ex(3'b010,0,1,2'b00,0,0,0,0,1));
        // bne with zero=1: not taken
        set_in(6'b000101, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b01);
        zero = 1'b1;
        cyc("bne_if",  ex(3'b000,1,0,2'b00,0,0,0,0,0));
        cyc("bne_id",  ex(3'b001,0,0,2'b00,0,0,0,0,0));
        cyc("bne_exe", ex(3'b010,0,1,2'b00,0,0,0,0,1));
        // sign branch with sign=1: taken
        set_in(6'b000110, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b10);
        zero = 1'b0; sign = 1'b1;
        cyc("bsg_if",  ex(3'b000,1,0,2'b00,0,0,0,0,0));
        cyc("bsg_id",  ex(3'b001,0,0,2'b00,0,0,0,0,0));
        cyc("bsg_exe", ex(3'b010,0,1,2'b01,0,0,0,0,1));
        // zero_op 11 never taken even with all flags set
        set_in(6'b000100, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b11);
        zero = 1'b1;
        cyc("bnv_if",  ex(3'b000,1,0,2'b00,0,0,0,0,0));
        cyc("bnv_id",  ex(3'b001,0,0,2'b00,0,0,0,0,0));
        cyc("bnv_exe", ex(3'b010,0,1,2'b00,0,0,0,0,1));
        sign = 1'b0; zero = 1'b0;

        // lw with two wait cycles: 7 cycles total.
        set_in(6'b100011, 6'b000000, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00);
        mem_ready = 1'b0;
        cyc("lw_if",   ex(3'b000,1,0,2'b00,0,0,0,0,0));
        cyc("lw_id",   ex(3'b001,0,0,2'b00,0,0,0,0,0));
        cyc("lw_exe",  ex(3'b010,0,0,2'b00,0,0,0,0,0));
        cyc("lw_mem0", ex(3'b011,0,0,2'b00,0,0,1,0,0));
        cyc("lw_mem1", ex(3'b011,0,0,2'b00,0,0,1,0,0));
        mem_ready = 1'b1;
        cyc("lw_mem2", ex(3'b011,0,0,2'b00,0,0,1,0,0));
        cyc("lw_wb",   ex(3'b100,0,1,2'b00,1,0,0,0,1));

        // sw with immediate ready: retires from MEM.
        set_in(6'b101011, 6'b000000, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00);
        cyc("sw_if",  ex(3'b000,1,0,2'b00,0,0,0,0,0));
        cyc("sw_id",  ex(3'b001,0,0,2'b00,0,0,0,0,0));
        cyc("sw_exe", ex(3'b010,0,0,2'b00,0,0,0,0,0));
        cyc("sw_mem", ex(3'b011,0,1,2'b00,0,1,0,0,1));

        // ALU with PCWrite low: pc_we gated, pc_src stays 00.
        set_in(6'b000000, 6'b100010, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
        cyc("alunp_if",  ex(3'b000,1,0,2'b00,0,0,0,0,0));
        cyc("alunp_id",  ex(3'b001,0,0,2'b00,0,0,0,0,0));
        cyc("alunp_exe", ex(3'b010,0,0,2'b00,0,0,0,0,0));
        cyc("alunp_wb",  ex(3'b100,0,0,2'b00,1,0,0,0,1));

        // jal: link write and jump in ID.
        set_in(6'b000011, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00);
        cyc("jal_if", ex(3'b000,1,0,2'b00,0,0,0,0,0));
        cyc("jal_id", ex(3'b001,0,1,2'b10,1,0,0,0,1));
        // jr (op 0, func 001000) is also a jump.
        set_in(6'b000000, 6'b001000, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00);
        cyc("jr_if", ex(3'b000,1,0,2'b00,0,0,0,0,0));
        cyc("jr_id", ex(3'b001,0,1,2'b11,0,0,0,0,1));

        // halt: parks in HALT until reset.
        set_in(6'b111111, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        cyc("hlt_if", ex(3'b000,1,0,2'b00,0,0,0,0,0));
        cyc("hlt_id", ex(3'b001,0,0,2'b00,0,0,0,0,1));
        for (int i = 0; i < 10; i++) begin
            cyc($sformatf("hlt_idle%0d", i), ex(3'b101,0,0,2'b00,0,0,0,1,0));
        end
        rst_n = 1'b0;
        #1;
        check("hlt_rst", {20'd0, obs}, {20'd0, ex(3'b000,0,0,2'b00,0,0,0,0,0)});
        @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted mid-lw while waiting in MEM.
        set_in(6'b100011, 6'b000000, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00);
        mem_ready = 1'b0;
        cyc("lwr_if",  ex(3'b000,1,0,2'b00,0,0,0,0,0));
        cyc("lwr_id",  ex(3'b001,0,0,2'b00,0,0,0,0,0));
        cyc("lwr_exe", ex(3'b010,0,0,2'b00,0,0,0,0,0));
        #1;
        check("lwr_mem", {20'd0, obs}, {20'd0, ex(3'b011,0,0,2'b00,0,0,1,0,0)});
        rst_n = 1'b0;
        #1;
        check("lwr_rst", {20'd0, obs}, {20'd0, ex(3'b000,0,0,2'b00,0,0,0,0,0)});
        check("lwr_cyc", cycle_cnt, 32'd0);
        check("lwr_ins", instr_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef SEQ_PERF_CNT_EN
        // Two jal instructions: 4 clocks, 2 retirements.
        set_in(6'b000011, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00);
        cyc("cnt_if0", ex(3'b000,1,0,2'b00,0,0,0,0,0));
        cyc("cnt_id0", ex(3'b001,0,1,2'b10,1,0,0,0,1));
        cyc("cnt_if1", ex(3'b000,1,0,2'b00,0,0,0,0,0));
        cyc("cnt_id1", ex(3'b001,0,1,2'b10,1,0,0,0,1));
        #1;
        check("cnt_cyc", cycle_cnt, 32'd4);
        check("cnt_ins", instr_cnt, 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
